// File: rtl/cu_pipe_pkg.sv
// Shared definitions for the control-word bubble pipeline.
// Holds the FSM state encoding and the bit value a bubble is built from.
package cu_pipe_pkg;

    // RUN: stage 0 accepts ctrl_in. INJECT: stage 0 receives bubbles.
    typedef enum logic {
        RUN    = 1'b0,
        INJECT = 1'b1
    } cu_state_t;

    // A bubble is an all-zero control word with its valid bit clear.
    // Every bit of a bubble stage register takes this value.
    localparam logic BUBBLE_BIT = 1'b0;

endpackage

// File: rtl/cu_pipe_stage.sv
// One control pipeline stage: a {valid, control word} register.
// Async reset and the synchronous clear both leave a bubble; clear wins over load.
module cu_pipe_stage
    import cu_pipe_pkg::*;
#(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // Stage register: reset or clear inserts a bubble, otherwise load the predecessor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= {W{BUBBLE_BIT}};
        end else if (clr_i) begin
            data_q <= {W{BUBBLE_BIT}};
        end else if (ld_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/cu_bubble_pipe.sv
// Control-word pipeline with stall, multi-cycle bubble runs and branch flush.
// Stage 0 is the youngest; stage k holds ctrl_in from k+1 edges ago.
// Optional build macro CU_BUBBLE_STATS_EN adds a saturating bubble counter port.
module cu_bubble_pipe
    import cu_pipe_pkg::*;
#(
    parameter int CW      = 24,
    parameter int DEPTH   = 3,
    parameter int FLUSH_N = 2,
    parameter int BL_W    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CW-1:0]         ctrl_in,
    input  logic                  valid_in,
    input  logic                  stall,
    input  logic                  bubble_req,
    input  logic [BL_W-1:0]       bubble_len,
    input  logic                  flush,
    output logic [DEPTH*CW-1:0]   ctrl_out,
    output logic [DEPTH-1:0]      valid_out,
    output logic                  in_ready,
    output logic                  busy
`ifdef CU_BUBBLE_STATS_EN
    ,
    output logic [15:0]           bubble_cnt
`endif
);

    cu_state_t             state_q;
    logic [BL_W-1:0]       cnt_q;
    logic                  in_run;
    logic                  bub_req_ok;
    logic [DEPTH-1:0]      stage_clr;
    logic [DEPTH-1:0][CW:0] stage_d;
    logic [DEPTH-1:0][CW:0] stage_q;

    assign in_run     = (state_q == RUN);
    // A zero-length request is treated as no request; requests are ignored in INJECT.
    assign bub_req_ok = in_run && bubble_req && (bubble_len != '0);
    // Stage 0 only takes ctrl_in when no hazard or bubble source claims it.
    assign in_ready   = in_run && !flush && !stall && !bub_req_ok;
    assign busy       = (state_q == INJECT);

    // Bubble-run FSM: flush aborts any run; a run of L inserts L bubbles in total.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else if (flush) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    // The request edge itself inserts the first bubble, so L-1 remain.
                    if (bub_req_ok && (bubble_len > BL_W'(1))) begin
                        state_q <= INJECT;
                        cnt_q   <= bubble_len - BL_W'(1);
                    end
                end
                INJECT: begin
                    if (cnt_q == BL_W'(1)) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - BL_W'(1);
                    end
                end
                default: begin
                    state_q <= RUN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Stage 0 is bubbled by every non-load cause (flush, run, stall, INJECT);
    // older stages shift unconditionally and only the FLUSH_N youngest see flush.
    always_comb begin
        stage_clr    = '0;
        stage_d      = '0;
        stage_clr[0] = !in_ready;
        stage_d[0]   = {valid_in, ctrl_in};
        for (int k = 1; k < DEPTH; k++) begin
            stage_clr[k] = flush && (k < FLUSH_N);
            stage_d[k]   = stage_q[k-1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        cu_pipe_stage #(
            .W (CW + 1)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .clr_i (stage_clr[k]),
            .ld_i  (1'b1),
            .d_i   (stage_d[k]),
            .q_o   (stage_q[k])
        );

        assign ctrl_out[k*CW +: CW] = stage_q[k][CW-1:0];
        assign valid_out[k]         = stage_q[k][CW];
    end

`ifdef CU_BUBBLE_STATS_EN
    logic [15:0] bubble_cnt_q;

    // Count every edge that puts a bubble into stage 0, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else if (!in_ready && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_cu_bubble_pipe.sv
// Self-checking bench for cu_bubble_pipe (default parameters).
// A behavioural model tracks the pipeline as an array of {word, valid} slots and a
// count of bubbles still owed to an active run; a negedge process compares every cycle.
module tb_cu_bubble_pipe;

    localparam int CW      = 24;
    localparam int DEPTH   = 3;
    localparam int FLUSH_N = 2;
    localparam int BL_W    = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [CW-1:0]       ctrl_in = '0;
    logic                valid_in = 1'b0;
    logic                stall = 1'b0;
    logic                bubble_req = 1'b0;
    logic [BL_W-1:0]     bubble_len = '0;
    logic                flush = 1'b0;
    logic [DEPTH*CW-1:0] ctrl_out;
    logic [DEPTH-1:0]    valid_out;
    logic                in_ready;
    logic                busy;
`ifdef CU_BUBBLE_STATS_EN
    logic [15:0]         bubble_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    cu_bubble_pipe #(
        .CW(CW), .DEPTH(DEPTH), .FLUSH_N(FLUSH_N), .BL_W(BL_W)
    ) dut (
        .clk        (clk),
        .reset      (rst),
        .ctrl_in    (ctrl_in),
        .valid_in   (valid_in),
        .stall      (stall),
        .bubble_req (bubble_req),
        .bubble_len (bubble_len),
        .flush      (flush),
        .ctrl_out   (ctrl_out),
        .valid_out  (valid_out),
        .in_ready   (in_ready),
        .busy       (busy)
`ifdef CU_BUBBLE_STATS_EN
        ,
        .bubble_cnt (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [CW-1:0] m_w [DEPTH];
    logic          m_v [DEPTH];
    int            m_owed = 0;   // bubbles still to come from an active run
    int            m_stat = 0;

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            m_w[k] = '0;
            m_v[k] = 1'b0;
        end
    end

    function automatic logic exp_ready();
        return (m_owed == 0) && !flush && !stall && !(bubble_req && bubble_len != 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                m_w[k] = '0;
                m_v[k] = 1'b0;
            end
            m_owed = 0;
            m_stat = 0;
        end else begin
            logic take;
            take = exp_ready();
            for (int k = DEPTH - 1; k >= 1; k--) begin
                if (flush && k < FLUSH_N) begin
                    m_w[k] = '0;
                    m_v[k] = 1'b0;
                end else begin
                    m_w[k] = m_w[k-1];
                    m_v[k] = m_v[k-1];
                end
            end
            m_w[0] = take ? ctrl_in : '0;
            m_v[0] = take ? valid_in : 1'b0;
            if (!take && m_stat < 65535) m_stat = m_stat + 1;
            if (flush) m_owed = 0;
            else if (m_owed > 0) m_owed = m_owed - 1;
            else if (bubble_req && bubble_len != 0) m_owed = int'(bubble_len) - 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [DEPTH*CW-1:0] ew;
        logic [DEPTH-1:0]    ev;
        for (int k = 0; k < DEPTH; k++) begin
            ew[k*CW +: CW] = m_w[k];
            ev[k]          = m_v[k];
        end
        chk("ctrl_out", 128'(ctrl_out), 128'(ew));
        chk("valid_out", 128'(valid_out), 128'(ev));
        chk("busy", 128'(busy), 128'(m_owed > 0));
        chk("in_ready", 128'(in_ready), 128'(exp_ready()));
`ifdef CU_BUBBLE_STATS_EN
        chk("bubble_cnt", 128'(bubble_cnt), 128'(m_stat));
`endif
    end

    // Drive one cycle of inputs, wait for the edge, settle 1 time unit past it.
    task automatic cyc(input logic v, input logic [CW-1:0] w, input logic st,
                       input logic br, input logic [BL_W-1:0] bl, input logic fl);
        valid_in   = v;
        ctrl_in    = w;
        stall      = st;
        bubble_req = br;
        bubble_len = bl;
        flush      = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] stg(input int k);
        return ctrl_out[k*CW +: CW];
    endfunction

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", 128'(ctrl_out), 128'(0));
        chk("rst_valid", 128'(valid_out), 128'(0));
        chk("rst_ready", 128'(in_ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        rst = 1'b0;

        // Streaming: A5A5A5 reaches stage 0 after 1 edge, stage 2 after 3
        cyc(1'b1, 24'hA5A5A5, 0, 0, 0, 0);
        chk("stream_s0", 128'(stg(0)), 128'(24'hA5A5A5));
        chk("stream_v0", 128'(valid_out[0]), 128'(1));
        cyc(1'b1, 24'h111111, 0, 0, 0, 0);
        cyc(1'b1, 24'h222222, 0, 0, 0, 0);
        chk("stream_s2", 128'(stg(2)), 128'(24'hA5A5A5));
        chk("stream_v2", 128'(valid_out[2]), 128'(1));

        // Stall: one bubble in stage 0, in_ready low that cycle
        valid_in = 1'b1; ctrl_in = 24'h333333; stall = 1'b1;
        #1 chk("stall_ready", 128'(in_ready), 128'(0));
        cyc(1'b1, 24'h333333, 1, 0, 0, 0);
        chk("stall_s0", 128'({valid_out[0], stg(0)}), 128'(0));
        cyc(1'b1, 24'h444444, 0, 0, 0, 0);
        chk("stall_s0_next", 128'({valid_out[0], stg(0)}), 128'({1'b1, 24'h444444}));
        cyc(1'b1, 24'h555555, 0, 0, 0, 0);
        chk("stall_s2", 128'({valid_out[2], stg(2)}), 128'(0));

        // Bubble run of 3: three bubbles, busy for two cycles
        cyc(1'b1, 24'h666666, 0, 1, 3'd3, 0);
        chk("run_b1", 128'(valid_out[0]), 128'(0));
        chk("run_busy1", 128'(busy), 128'(1));
        cyc(1'b1, 24'h777777, 0, 0, 0, 0);
        chk("run_b2", 128'(valid_out[0]), 128'(0));
        chk("run_busy2", 128'(busy), 128'(1));
        cyc(1'b1, 24'h888888, 0, 0, 0, 0);
        chk("run_b3", 128'(valid_out[0]), 128'(0));
        chk("run_busy3", 128'(busy), 128'(0));
        cyc(1'b1, 24'h999999, 0, 0, 0, 0);
        chk("run_load", 128'({valid_out[0], stg(0)}), 128'({1'b1, 24'h999999}));

        // Zero-length request is no request
        cyc(1'b1, 24'hABCDEF, 0, 1, 3'd0, 0);
        chk("len0_load", 128'({valid_out[0], stg(0)}), 128'({1'b1, 24'hABCDEF}));

        // Flush on the 2nd INJECT cycle of a length-5 run
        cyc(1'b1, 24'h0000C1, 0, 1, 3'd5, 0);
        cyc(1'b1, 24'h0000C2, 0, 0, 0, 0);
        cyc(1'b1, 24'h0000C3, 0, 0, 0, 1);
        chk("flush_busy", 128'(busy), 128'(0));
        chk("flush_s01", 128'({valid_out[1:0], stg(1), stg(0)}), 128'(0));
        cyc(1'b1, 24'h0000C4, 0, 0, 0, 0);
        chk("flush_load", 128'({valid_out[0], stg(0)}), 128'({1'b1, 24'h0000C4}));

        // Flush with stall and bubble_req: flush only, no INJECT
        cyc(1'b1, 24'h0000D1, 1, 1, 3'd4, 1);
        chk("simul_busy", 128'(busy), 128'(0));
        cyc(1'b1, 24'h0000D2, 0, 0, 0, 0);
        chk("simul_load", 128'({valid_out[0], stg(0)}), 128'({1'b1, 24'h0000D2}));

        // Async reset mid-INJECT clears everything before the next edge
        cyc(1'b1, 24'h0000E1, 0, 1, 3'd6, 0);
        cyc(1'b1, 24'h0000E2, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("arst_ctrl", 128'(ctrl_out), 128'(0));
        chk("arst_valid", 128'(valid_out), 128'(0));
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_ready", 128'(in_ready), 128'(1));
        cyc(1'b1, 24'h0000E3, 0, 0, 0, 0);
        rst = 1'b0;

`ifdef CU_BUBBLE_STATS_EN
        // Two stalls plus a run of 4 give six bubbles
        rst = 1'b1;
        cyc(0, '0, 0, 0, 0, 0);
        rst = 1'b0;
        cyc(1, 24'h1, 1, 0, 0, 0);
        cyc(1, 24'h2, 0, 0, 0, 0);
        cyc(1, 24'h3, 1, 0, 0, 0);
        cyc(1, 24'h4, 0, 1, 3'd4, 0);
        repeat (4) cyc(1, 24'h5, 0, 0, 0, 0);
        chk("stats_six", 128'(bubble_cnt), 128'(6));
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), CW'($urandom),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 9) == 0),
                BL_W'($urandom_range(0, 7)),
                ($urandom_range(0, 11) == 0));
        end
        cyc(0, '0, 0, 0, 0, 0);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
